// File: rtl/dmem_store_buf_pkg.sv
// Shared types and byte-lane helpers for the data-memory store buffer.
package dmem_store_buf_pkg;

   localparam int MEM_W = 32;
   localparam int BE_W  = 4;

   typedef logic [MEM_W-1:0] mem_bus_t;
   typedef logic [31:0]      mem_addr_bus_t;
   typedef logic [BE_W-1:0]  be_t;

   // Per byte lane: take upd where mask is set, otherwise keep base.
   function automatic mem_bus_t lane_merge(input mem_bus_t base, input mem_bus_t upd,
                                           input be_t mask);
      mem_bus_t res;
      res = base;
      for (int b = 0; b < BE_W; b++) begin
         if (mask[b]) begin
            res[8*b +: 8] = upd[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_store_buf_sb_fifo.sv
// Circular store queue; every slot is exposed so the parent can scan for forwarding.
module dmem_store_buf_sb_fifo
   import dmem_store_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push_i,
   input  logic [AW-1:0]                    push_addr_i,
   input  logic [BE_W-1:0]                  push_be_i,
   input  logic [MEM_W-1:0]                 push_data_i,
   input  logic                             pop_i,
   output logic [PTR_W-1:0]                 head_o,
   output logic [PTR_W:0]                   count_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [DEPTH-1:0][AW-1:0]         ent_addr_o,
   output logic [DEPTH-1:0][BE_W-1:0]       ent_be_o,
   output logic [DEPTH-1:0][MEM_W-1:0]      ent_data_o
);

   logic [DEPTH-1:0][AW-1:0]    ent_addr_q, ent_addr_d;
   logic [DEPTH-1:0][BE_W-1:0]  ent_be_q,   ent_be_d;
   logic [DEPTH-1:0][MEM_W-1:0] ent_data_q, ent_data_d;
   logic [PTR_W-1:0]            head_q, head_d;
   logic [PTR_W-1:0]            tail_q, tail_d;
   logic [PTR_W:0]              count_q, count_d;
   logic                        push_ok;
   logic                        pop_ok;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      ent_addr_d = ent_addr_q;
      ent_be_d   = ent_be_q;
      ent_data_d = ent_data_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (push_ok) begin
         ent_addr_d[tail_q] = push_addr_i;
         ent_be_d[tail_q]   = push_be_i;
         ent_data_d[tail_q] = push_data_i;
         tail_d             = tail_q + 1'b1;
      end
      if (pop_ok) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_addr_q <= '0;
         ent_be_q   <= '0;
         ent_data_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         ent_addr_q <= ent_addr_d;
         ent_be_q   <= ent_be_d;
         ent_data_q <= ent_data_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   assign head_o     = head_q;
   assign count_o    = count_q;
   assign ent_addr_o = ent_addr_q;
   assign ent_be_o   = ent_be_q;
   assign ent_data_o = ent_data_q;

endmodule

// File: rtl/dmem_store_buf.sv
// Store buffer and single-port RAM arbiter: loads win the port, stores drain when it is free,
// and buffered store bytes are forwarded into load data.
module dmem_store_buf
   import dmem_store_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 12,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BE_W-1:0]  wen_i,
   input  logic [31:0]      waddr_i,
   input  logic [MEM_W-1:0] wdata_i,
   input  logic             ren_i,
   input  logic [31:0]      raddr_i,
   output logic [MEM_W-1:0] rdata_o,
   output logic             rvalid_o,
   output logic             full_o,
   output logic             ram_en_o,
   output logic [BE_W-1:0]  ram_we_o,
   output logic [AW-1:0]    ram_addr_o,
   output logic [MEM_W-1:0] ram_wdata_o,
   input  logic [MEM_W-1:0] ram_rdata_i
);

   logic [AW-1:0]                waddr_word;
   logic [AW-1:0]                raddr_word;
   logic                         push;
   logic                         rd_acc;
   logic                         pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [PTR_W-1:0]             head;
   logic [PTR_W:0]               count;
   logic [DEPTH-1:0][AW-1:0]     ent_addr;
   logic [DEPTH-1:0][BE_W-1:0]   ent_be;
   logic [DEPTH-1:0][MEM_W-1:0]  ent_data;
   logic [PTR_W-1:0]             scan_idx;
   logic [MEM_W-1:0]             fwd_data_q, fwd_data_d;
   logic [BE_W-1:0]              fwd_mask_q, fwd_mask_d;
   logic                         rvalid_q, rvalid_d;
   logic                         unused_addr_bits;

   // Word index only; byte offset and high bits alias by design.
   assign waddr_word       = waddr_i[AW+1:2];
   assign raddr_word       = raddr_i[AW+1:2];
   assign unused_addr_bits = ^{waddr_i[31:AW+2], waddr_i[1:0], raddr_i[31:AW+2], raddr_i[1:0]};

   assign full_o = fifo_full;
   assign push   = (|wen_i) && !fifo_full;
   assign rd_acc = ren_i && !fifo_full;
   assign pop    = !rd_acc && !fifo_empty;

   dmem_store_buf_sb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PTR_W (PTR_W)
   ) u_sb_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_addr_i (waddr_word),
      .push_be_i   (wen_i),
      .push_data_i (wdata_i),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .ent_addr_o  (ent_addr),
      .ent_be_o    (ent_be),
      .ent_data_o  (ent_data)
   );

   // Oldest to youngest, so later matches overwrite earlier ones; the same-cycle store is youngest.
   always_comb begin
      fwd_data_d = '0;
      fwd_mask_d = '0;
      scan_idx   = '0;
      rvalid_d   = rd_acc;
      if (rd_acc) begin
         for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (ent_addr[scan_idx] == raddr_word)) begin
               fwd_data_d = lane_merge(fwd_data_d, ent_data[scan_idx], ent_be[scan_idx]);
               fwd_mask_d = fwd_mask_d | ent_be[scan_idx];
            end
         end
         if (push && (waddr_word == raddr_word)) begin
            fwd_data_d = lane_merge(fwd_data_d, wdata_i, wen_i);
            fwd_mask_d = fwd_mask_d | wen_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_data_q <= '0;
         fwd_mask_q <= '0;
         rvalid_q   <= 1'b0;
      end else begin
         fwd_data_q <= fwd_data_d;
         fwd_mask_q <= fwd_mask_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rvalid_q ? lane_merge(ram_rdata_i, fwd_data_q, fwd_mask_q) : '0;

   // RAM port is held quiet while reset is asserted, even if a load is presented.
   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (rst) begin
         if (rd_acc) begin
            ram_en_o   = 1'b1;
            ram_addr_o = raddr_word;
         end else if (pop) begin
            ram_en_o    = 1'b1;
            ram_we_o    = ent_be[head];
            ram_addr_o  = ent_addr[head];
            ram_wdata_o = ent_data[head];
         end
      end
   end

endmodule
